player_physics: RTL and testbench

//  Per-frame player motion engine for the platformer: keyboard walk, jump, gravity and landing on platforms/floor.

---
 rtl/player_pkg.sv | 19 +
 rtl/sat_accum.sv | 24 ++
 rtl/player_physics.sv | 160 ++++++++++++++++
 tb/tb_player_physics.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and fixed-point widths for the player motion engine.
package player_pkg;

    localparam int unsigned FRAC_BITS = 4;
    localparam int unsigned VW        = 12;
    localparam int unsigned POS_W     = 10 + FRAC_BITS;
    localparam int unsigned SUM_W     = VW + 11;

    localparam logic [7:0] KEY_LEFT  = 8'd4;
    localparam logic [7:0] KEY_RIGHT = 8'd7;
    localparam logic [7:0] KEY_JUMP  = 8'd26;

    typedef enum logic [1:0] {
        P_GROUND = 2'd0,
        P_JUMP   = 2'd1,
        P_FALL   = 2'd2
    } p_state_t;

endpackage

// File: rtl/sat_accum.sv
// Signed add with the result clamped to [MIN, MAX]; one guard bit keeps the raw sum exact.
module sat_accum #(
    parameter int unsigned         W   = 12,
    parameter logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}},
    parameter logic signed [W-1:0] MAX = {1'b0, {(W-1){1'b1}}}
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum_c
);

    logic signed [W:0] raw_c;

    always_comb begin
        raw_c = (W+1)'(a) + (W+1)'(b);
        sum_c = raw_c[W-1:0];
        if (raw_c < (W+1)'(MIN)) begin
            sum_c = MIN;
        end else if (raw_c > (W+1)'(MAX)) begin
            sum_c = MAX;
        end
    end

endmodule

// File: rtl/player_physics.sv
// Per-frame player motion: walk, jump, gravity, ceiling and landing on platforms/floor.
// Position is sub-pixel fixed point; each step adds the velocity computed on the same edge.
module player_physics
    import player_pkg::*;
#(
    parameter int unsigned X_START  = 280,
    parameter int unsigned Y_START  = 470,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned SIZE_X   = 8,
    parameter int unsigned SIZE_Y   = 10,
    parameter int unsigned X_STEP   = 16,
    parameter int unsigned GRAVITY  = 4,
    parameter int unsigned JUMP_V   = 96,
    parameter int unsigned MAX_FALL = 128
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       platform_hit,
    input  logic [9:0] platform_y,
    output logic [9:0] PlayerX,
    output logic [9:0] PlayerY,
    output logic [9:0] PlayerW,
    output logic [9:0] PlayerH,
    output logic [1:0] p_state,
    output logic       landed
);

    localparam logic signed [SUM_W-1:0] X_LO_FP   = SUM_W'(X_MIN << FRAC_BITS);
    localparam logic signed [SUM_W-1:0] X_HI_FP   = SUM_W'((X_MAX - SIZE_X + 1) << FRAC_BITS);
    localparam logic signed [SUM_W-1:0] Y_LO_FP   = SUM_W'(Y_MIN << FRAC_BITS);
    localparam logic signed [SUM_W-1:0] Y_MAX_S   = SUM_W'(Y_MAX);
    localparam logic signed [SUM_W-1:0] BOT_OFS_S = SUM_W'(SIZE_Y - 1);
    localparam logic signed [SUM_W-1:0] ONE_S     = SUM_W'(1);
    localparam logic [POS_W-1:0]        Y_FLOOR   = POS_W'((Y_MAX - SIZE_Y + 1) << FRAC_BITS);
    localparam logic [10:0]             Y_MAX_B   = 11'(Y_MAX);
    localparam logic [10:0]             BOT_OFS_B = 11'(SIZE_Y - 1);
    localparam logic signed [VW-1:0]    VX_STEP   = VW'(X_STEP);
    localparam logic signed [VW-1:0]    VY_JUMP   = VW'(JUMP_V);
    localparam logic signed [VW-1:0]    VY_GRAV   = VW'(GRAVITY);
    localparam logic signed [VW-1:0]    VY_MAXF   = VW'(MAX_FALL);
    localparam logic signed [VW-1:0]    VY_MINV   = {1'b1, {(VW-1){1'b0}}};

    p_state_t                 state_q, state_d;
    logic [POS_W-1:0]         x_q, x_d, y_q, y_d;
    logic signed [VW-1:0]     vy_q, vy_d, vy_new_c, vy_grav_c, vx_c;
    logic                     landed_q, landed_d;
    logic signed [SUM_W-1:0]  x_sum_c, y_sum_c, new_bot_c, plat_c;
    logic [10:0]              old_bot_c;
    logic                     supported_c, plat_land_c, floor_land_c;

    sat_accum #(.W(SUM_W), .MIN(X_LO_FP), .MAX(X_HI_FP)) u_x_clamp (
        .a     (SUM_W'($signed({1'b0, x_q}))),
        .b     (SUM_W'(vx_c)),
        .sum_c (x_sum_c)
    );

    sat_accum #(.W(VW), .MIN(VY_MINV), .MAX(VY_MAXF)) u_vy_grav (
        .a     (vy_q),
        .b     (VY_GRAV),
        .sum_c (vy_grav_c)
    );

    // Horizontal velocity is purely a function of the current key.
    always_comb begin
        vx_c = '0;
        if (keycode == KEY_LEFT) begin
            vx_c = -VX_STEP;
        end else if (keycode == KEY_RIGHT) begin
            vx_c = VX_STEP;
        end
    end

    // Standing on the floor, or on a platform whose top is directly below the sprite.
    always_comb begin
        old_bot_c   = 11'(y_q[POS_W-1:FRAC_BITS]) + BOT_OFS_B;
        supported_c = (old_bot_c >= Y_MAX_B) ||
                      (platform_hit && (11'(platform_y) == old_bot_c + 11'd1));
    end

    always_comb begin
        state_d  = state_q;
        landed_d = 1'b0;
        vy_new_c = '0;
        x_d      = POS_W'(x_sum_c);

        case (state_q)
            P_GROUND: begin
                if (keycode == KEY_JUMP) begin
                    vy_new_c = -VY_JUMP;
                    state_d  = P_JUMP;
                end else if (!supported_c) begin
                    state_d = P_FALL;
                end
            end
            P_JUMP: begin
                vy_new_c = vy_grav_c;
                if (!vy_grav_c[VW-1]) begin
                    state_d = P_FALL;
                end
            end
            P_FALL: begin
                vy_new_c = vy_grav_c;
            end
            default: begin
                state_d = P_GROUND;
            end
        endcase

        vy_d         = vy_new_c;
        y_sum_c      = SUM_W'($signed({1'b0, y_q})) + SUM_W'(vy_new_c);
        y_d          = POS_W'(y_sum_c);
        new_bot_c    = (y_sum_c >>> FRAC_BITS) + BOT_OFS_S;
        plat_c       = SUM_W'($signed({1'b0, platform_y}));
        plat_land_c  = platform_hit && (old_bot_c < 11'(platform_y)) && (new_bot_c >= plat_c - ONE_S);
        floor_land_c = (new_bot_c >= Y_MAX_S);

        // Upward motion past the ceiling stops dead and starts the fall.
        if (y_sum_c < Y_LO_FP) begin
            y_d     = POS_W'(Y_LO_FP);
            vy_d    = '0;
            state_d = P_FALL;
        end

        // Platform snap takes priority over the floor.
        if ((state_q == P_FALL) && (plat_land_c || floor_land_c)) begin
            y_d      = plat_land_c ? {platform_y - 10'(SIZE_Y), {FRAC_BITS{1'b0}}} : Y_FLOOR;
            vy_d     = '0;
            state_d  = P_GROUND;
            landed_d = 1'b1;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q      <= POS_W'(X_START << FRAC_BITS);
            y_q      <= POS_W'(Y_START << FRAC_BITS);
            vy_q     <= '0;
            state_q  <= P_GROUND;
            landed_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
            state_q  <= state_d;
            landed_q <= landed_d;
        end
    end

    assign PlayerX = x_q[POS_W-1:FRAC_BITS];
    assign PlayerY = y_q[POS_W-1:FRAC_BITS];
    assign PlayerW = 10'(SIZE_X);
    assign PlayerH = 10'(SIZE_Y);
    assign p_state = state_q;
    assign landed  = landed_q;

endmodule

// File: tb/tb_player_physics.sv
// Self-checking bench for player_physics: vector table, directed corner sequences
// and a randomized run against a frame-level arithmetic model.
module tb_player_physics;

    logic       frame_clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       platform_hit;
    logic [9:0] platform_y;
    logic [9:0] px, py, pw, ph;
    logic [1:0] pst;
    logic       pland;

    logic [7:0] key2;
    logic [9:0] px2, py2, pw2, ph2;
    logic [1:0] pst2;
    logic       pland2;

    logic       hit3;
    logic [9:0] pyin3;
    logic [9:0] px3, py3, pw3, ph3;
    logic [1:0] pst3;
    logic       pland3;

    int n_cmp = 0;
    int n_bad = 0;

    int m_x, m_y, m_vy, m_st, m_land;

    always #5 frame_clk = ~frame_clk;

    player_physics dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
        .platform_hit(platform_hit), .platform_y(platform_y),
        .PlayerX(px), .PlayerY(py), .PlayerW(pw), .PlayerH(ph),
        .p_state(pst), .landed(pland)
    );

    player_physics #(.Y_START(20)) dut_ceil (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(key2),
        .platform_hit(1'b0), .platform_y(10'd0),
        .PlayerX(px2), .PlayerY(py2), .PlayerW(pw2), .PlayerH(ph2),
        .p_state(pst2), .landed(pland2)
    );

    player_physics #(.Y_START(100)) dut_fall (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(8'd0),
        .platform_hit(hit3), .platform_y(pyin3),
        .PlayerX(px3), .PlayerY(py3), .PlayerW(pw3), .PlayerH(ph3),
        .p_state(pst3), .landed(pland3)
    );

    typedef struct {
        logic [7:0] key;
        logic       hit;
        logic [9:0] pyv;
        int         ex;
        int         ey;
        int         est;
        int         el;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    // Asserts reset and releases it before the next rising edge.
    task automatic do_reset();
        @(negedge frame_clk);
        Reset_n      = 1'b0;
        keycode      = 8'd0;
        platform_hit = 1'b0;
        platform_y   = 10'd0;
        key2         = 8'd0;
        #2;
        Reset_n = 1'b1;
    endtask

    task automatic model_reset();
        m_x = 280 * 16; m_y = 470 * 16; m_vy = 0; m_st = 0; m_land = 0;
    endtask

    // One frame of the player rules in plain 1/16-pixel integer arithmetic.
    task automatic model_step(input int k, input int hit, input int pyv);
        int vx, nx, obot, nvy, nst, ny, nbot, land;
        vx = (k == 4) ? -16 : ((k == 7) ? 16 : 0);
        nx = m_x + vx;
        if (nx < 0) nx = 0;
        if (nx > 632 * 16) nx = 632 * 16;
        obot = m_y / 16 + 9;
        nst = m_st; nvy = 0; land = 0;
        if (m_st == 0) begin
            if (k == 26) begin
                nvy = -96; nst = 1;
            end else if (obot < 479 && !(hit != 0 && pyv == obot + 1)) begin
                nst = 2;
            end
        end else if (m_st == 1) begin
            nvy = m_vy + 4;
            if (nvy >= 0) nst = 2;
        end else begin
            nvy = m_vy + 4;
            if (nvy > 128) nvy = 128;
        end
        ny = m_y + nvy;
        if (ny < 0) begin
            ny = 0; nvy = 0; nst = 2;
        end
        if (m_st == 2) begin
            nbot = ny / 16 + 9;
            if (hit != 0 && obot < pyv && nbot >= pyv - 1) begin
                ny = (pyv - 10) * 16; land = 1;
            end else if (nbot >= 479) begin
                ny = 470 * 16; land = 1;
            end
            if (land != 0) begin
                nvy = 0; nst = 0;
            end
        end
        m_x = nx; m_y = ny; m_vy = nvy; m_st = nst; m_land = land;
    endtask

    initial begin
        int frames, got, maxd, maxy, prev, reached, maxx;
        int lx [5];
        int keys [10];
        int k, h, pv;

        Reset_n = 1'b0; keycode = 8'd0; platform_hit = 1'b0; platform_y = 10'd0;
        key2 = 8'd0; hit3 = 1'b1; pyin3 = 10'd300;

        vecs[0] = '{8'd0,  1'b0, 10'd0,   280, 470, 0, 0};
        vecs[1] = '{8'd0,  1'b1, 10'd300, 280, 470, 0, 0};
        vecs[2] = '{8'd7,  1'b0, 10'd0,   281, 470, 0, 0};
        vecs[3] = '{8'd7,  1'b0, 10'd0,   282, 470, 0, 0};
        vecs[4] = '{8'd4,  1'b0, 10'd0,   281, 470, 0, 0};
        vecs[5] = '{8'd26, 1'b0, 10'd0,   281, 464, 1, 0};
        vecs[6] = '{8'd26, 1'b0, 10'd0,   281, 458, 1, 0};
        vecs[7] = '{8'd7,  1'b0, 10'd0,   282, 452, 1, 0};
        vecs[8] = '{8'd0,  1'b0, 10'd0,   282, 447, 1, 0};
        vecs[9] = '{8'd4,  1'b0, 10'd0,   281, 442, 1, 0};

        // Reset state and vector table
        do_reset();
        check("rst_x", int'(px), 280);
        check("rst_y", int'(py), 470);
        check("rst_state", int'(pst), 0);
        check("rst_landed", int'(pland), 0);
        check("rst_w", int'(pw), 8);
        check("rst_h", int'(ph), 10);
        for (int i = 0; i < 10; i++) begin
            keycode = vecs[i].key; platform_hit = vecs[i].hit; platform_y = vecs[i].pyv;
            step();
            check($sformatf("vec%0d_x", i), int'(px), vecs[i].ex);
            check($sformatf("vec%0d_y", i), int'(py), vecs[i].ey);
            check($sformatf("vec%0d_state", i), int'(pst), vecs[i].est);
            check($sformatf("vec%0d_landed", i), int'(pland), vecs[i].el);
        end

        // Full jump arc from the floor
        do_reset();
        keycode = 8'd26;
        step();
        check("jump_y1", int'(py), 464);
        check("jump_state1", int'(pst), 1);
        keycode = 8'd0;
        repeat (23) step();
        check("apex_y", int'(py), 395);
        check("apex_state", int'(pst), 1);
        step();
        check("apex_fall_y", int'(py), 395);
        check("apex_fall_state", int'(pst), 2);
        frames = 0; got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            step();
            frames++;
            if (pland) got = 1;
        end
        check("fall_frames", frames, 24);
        check("land_y", int'(py), 470);
        check("land_state", int'(pst), 0);
        step();
        check("land_pulse_clear", int'(pland), 0);
        check("after_land_y", int'(py), 470);

        // Left clamp then right clamp
        do_reset();
        keycode = 8'd4;
        repeat (277) step();
        check("left_x3", int'(px), 3);
        lx = '{2, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("left_clamp%0d", i), int'(px), lx[i]);
        end
        keycode = 8'd7;
        maxx = 0;
        for (int i = 0; i < 650; i++) begin
            step();
            if (int'(px) > maxx) maxx = int'(px);
        end
        check("right_x", int'(px), 632);
        check("right_max", maxx, 632);

        // Ceiling clamp on the Y_START=20 instance
        do_reset();
        key2 = 8'd26;
        step();
        check("ceil_y1", int'(py2), 14);
        check("ceil_st1", int'(pst2), 1);
        key2 = 8'd0;
        step();
        check("ceil_y2", int'(py2), 8);
        step();
        check("ceil_y3", int'(py2), 2);
        check("ceil_st3", int'(pst2), 1);
        step();
        check("ceil_y4", int'(py2), 0);
        check("ceil_st4", int'(pst2), 2);
        step();
        check("ceil_y5", int'(py2), 0);
        check("ceil_st5", int'(pst2), 2);

        // Long fall onto a platform at row 300 from Y=100
        do_reset();
        frames = 0; got = 0; maxd = 0; maxy = 0; prev = int'(py3);
        for (int i = 0; i < 60 && got == 0; i++) begin
            step();
            frames++;
            if (int'(py3) - prev > maxd) maxd = int'(py3) - prev;
            if (int'(py3) > maxy) maxy = int'(py3);
            prev = int'(py3);
            if (pland3) got = 1;
        end
        check("plat_frames", frames, 41);
        check("plat_y", int'(py3), 290);
        check("plat_state", int'(pst3), 0);
        check("plat_max_dy", maxd, 8);
        check("plat_max_y", maxy, 290);
        step();
        check("plat_pulse_clear", int'(pland3), 0);
        check("plat_hold_y", int'(py3), 290);
        check("plat_hold_state", int'(pst3), 0);

        // Asynchronous reset in mid-air
        do_reset();
        keycode = 8'd26;
        step();
        keycode = 8'd0;
        reached = 0;
        for (int i = 0; i < 20 && reached == 0; i++) begin
            step();
            if (int'(py) <= 420) reached = 1;
        end
        check("midair_reached", reached, 1);
        #1 Reset_n = 1'b0;
        #1;
        check("async_rst_x", int'(px), 280);
        check("async_rst_y", int'(py), 470);
        check("async_rst_state", int'(pst), 0);
        check("async_rst_landed", int'(pland), 0);
        Reset_n = 1'b1;
        step();
        check("post_rst_y", int'(py), 470);
        check("post_rst_state", int'(pst), 0);

        // Randomized frames against the model
        keys = '{0, 0, 4, 4, 7, 7, 26, 26, 9, 0};
        do_reset();
        model_reset();
        h = 0; pv = 300;
        for (int i = 0; i < 2000; i++) begin
            if (i % 16 == 0) begin
                h  = int'($urandom % 2);
                pv = int'($urandom_range(100, 479));
            end
            k = keys[$urandom_range(0, 9)];
            keycode = 8'(k); platform_hit = h[0]; platform_y = 10'(pv);
            model_step(k, h, pv);
            step();
            check($sformatf("rnd%0d_x", i), int'(px), m_x / 16);
            check($sformatf("rnd%0d_y", i), int'(py), m_y / 16);
            check($sformatf("rnd%0d_state", i), int'(pst), m_st);
            check($sformatf("rnd%0d_landed", i), int'(pland), m_land);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
